// File: rtl/gyro_cmd_encoder_if.sv
// Byte handshake between the gyro command encoder and the UART transmitter.
interface gyro_cmd_encoder_if;
    logic       tx_ready;
    logic       tx_send;
    logic [7:0] tx_data;

    modport master (input tx_ready, output tx_send, output tx_data);
    modport slave  (output tx_ready, input tx_send, input tx_data);
endinterface

// File: rtl/gyro_cmd_encoder.sv
// Round-robin gyro axis classifier emitting one command byte per tick slot.
// Optional GYRO_CMD_MAG_EN adds a 2-bit magnitude level in byte bits [7:6].
module gyro_cmd_encoder #(
    parameter int unsigned NUM_AXES   = 2,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEADZONE   = 4096,
    parameter int unsigned HYST       = 1024,
    parameter logic [7:0]  IDLE_BYTE  = 8'hFF,
    parameter logic [7:0]  RESET_BYTE = 8'h63,
    parameter int unsigned MAG_SHIFT  = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [NUM_AXES*DATA_W-1:0]   axis_data,
    input  logic                         enable,
    input  logic                         recenter,
    gyro_cmd_encoder_if.master           tx,
    output logic [3:0]                   cur_axis,
    output logic                         busy,
    output logic [7:0]                   drop_cnt
);

    localparam int AW = DATA_W + 1;
    localparam logic signed [AW-1:0] DZ_POS = AW'(DEADZONE);
    localparam logic signed [AW-1:0] DZ_NEG = -DZ_POS;
    localparam logic signed [AW-1:0] DZ_LOW = AW'(DEADZONE - HYST);
    localparam logic [3:0]           LAST_AXIS = 4'(NUM_AXES - 1);

    if (NUM_AXES < 1 || NUM_AXES > 16 || HYST >= DEADZONE || MAG_SHIFT >= AW) begin : g_bad_param
        $error("gyro_cmd_encoder: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_ISSUE} state_e;
    typedef enum logic [1:0] {AX_NEUTRAL, AX_NEG, AX_POS} axis_st_e;

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic [3:0]          cur_axis_q, cur_axis_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic                pending_q, pending_d;
    logic                slot_reset_q, slot_reset_d;
    logic [DATA_W-1:0]   snap_q, snap_d;
    logic [7:0]          tx_data_q, tx_data_d;
    axis_st_e            ax_state_q [NUM_AXES];
    axis_st_e            ax_state_d [NUM_AXES];

    logic signed [AW-1:0] v_ext;
    logic signed [AW-1:0] mag;
    axis_st_e             cur_st;
    axis_st_e             new_st;
    logic [2:0]           byte_hi;

`ifdef GYRO_CMD_MAG_EN
    localparam logic signed [AW-1:0] DZ_P1 = AW'(DEADZONE + 1);
    logic signed [AW-1:0] excess;
    logic [AW-1:0]        lvl_raw;
    logic [1:0]           level;

    // Below the deadzone (held state inside hysteresis band) the level is 0.
    always_comb begin
        excess  = mag - DZ_P1;
        lvl_raw = excess >> MAG_SHIFT;
        if (excess[AW-1])
            level = 2'd0;
        else if (lvl_raw > AW'(3))
            level = 2'd3;
        else
            level = lvl_raw[1:0];
    end
`endif

    assign tx.tx_send = (state_q == S_ISSUE) && tx.tx_ready;
    assign tx.tx_data = tx_data_q;
    assign cur_axis   = cur_axis_q;
    assign busy       = busy_q;
    assign drop_cnt   = drop_cnt_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        cur_axis_d   = cur_axis_q;
        drop_cnt_d   = drop_cnt_q;
        pending_d    = pending_q | recenter;
        slot_reset_d = slot_reset_q;
        snap_d       = snap_q;
        tx_data_d    = tx_data_q;
        ax_state_d   = ax_state_q;

        // Sign-extend one bit so negating the most negative sample cannot overflow.
        v_ext = signed'({snap_q[DATA_W-1], snap_q});
        mag   = v_ext[AW-1] ? -v_ext : v_ext;

        cur_st = AX_NEUTRAL;
        for (int i = 0; i < NUM_AXES; i++)
            if (4'(i) == cur_axis_q) cur_st = ax_state_q[i];

        new_st = cur_st;
        case (cur_st)
            AX_NEUTRAL: if (v_ext > DZ_POS) new_st = AX_POS;
                        else if (v_ext < DZ_NEG) new_st = AX_NEG;
            AX_POS:     if (v_ext < DZ_NEG) new_st = AX_NEG;
                        else if (mag < DZ_LOW) new_st = AX_NEUTRAL;
            AX_NEG:     if (v_ext > DZ_POS) new_st = AX_POS;
                        else if (mag < DZ_LOW) new_st = AX_NEUTRAL;
            default:    new_st = AX_NEUTRAL;
        endcase

`ifdef GYRO_CMD_MAG_EN
        byte_hi = {level, 1'b0};
`else
        byte_hi = 3'b000;
`endif

        if (tick && enable && busy_q && drop_cnt_q != 8'hFF)
            drop_cnt_d = drop_cnt_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (tick && enable) begin
                    busy_d       = 1'b1;
                    state_d      = S_CAPTURE;
                    slot_reset_d = pending_q | recenter;
                    for (int i = 0; i < NUM_AXES; i++)
                        if (4'(i) == cur_axis_q) snap_d = axis_data[i*DATA_W +: DATA_W];
                end
            end
            S_CAPTURE: begin
                if (slot_reset_q) begin
                    tx_data_d = RESET_BYTE;
                end else begin
                    for (int i = 0; i < NUM_AXES; i++)
                        if (4'(i) == cur_axis_q) ax_state_d[i] = new_st;
                    tx_data_d = (new_st == AX_NEUTRAL) ? IDLE_BYTE
                              : {byte_hi, cur_axis_q, new_st == AX_POS};
                end
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (tx.tx_ready) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    if (slot_reset_q)
                        pending_d = recenter;
                    else
                        cur_axis_d = (cur_axis_q == LAST_AXIS) ? 4'd0 : cur_axis_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            cur_axis_q   <= 4'd0;
            drop_cnt_q   <= 8'd0;
            pending_q    <= 1'b1;
            slot_reset_q <= 1'b0;
            snap_q       <= '0;
            tx_data_q    <= 8'd0;
            // NOTE: per-axis state is a handful of flops, not a RAM, so it is reset like any register.
            for (int i = 0; i < NUM_AXES; i++)
                ax_state_q[i] <= AX_NEUTRAL;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            cur_axis_q   <= cur_axis_d;
            drop_cnt_q   <= drop_cnt_d;
            pending_q    <= pending_d;
            slot_reset_q <= slot_reset_d;
            snap_q       <= snap_d;
            tx_data_q    <= tx_data_d;
            for (int i = 0; i < NUM_AXES; i++)
                ax_state_q[i] <= ax_state_d[i];
        end
    end

endmodule

// File: tb/tb_gyro_cmd_encoder.sv
// Directed self-checking bench for gyro_cmd_encoder (NUM_AXES=2, DATA_W=16).
module tb_gyro_cmd_encoder;

    localparam int NUM_AXES = 2;
    localparam int DATA_W   = 16;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       tick = 1'b0;
    logic                       enable = 1'b0;
    logic                       recenter = 1'b0;
    logic [NUM_AXES*DATA_W-1:0] axis_data = '0;
    logic [3:0]                 cur_axis;
    logic                       busy;
    logic [7:0]                 drop_cnt;

    int tests = 0;
    int fails = 0;
    int send_cnt = 0;
    int snap_cnt;

    gyro_cmd_encoder_if tx_if ();

    gyro_cmd_encoder #(
        .NUM_AXES  (NUM_AXES),
        .DATA_W    (DATA_W),
        .DEADZONE  (4096),
        .HYST      (1024),
        .IDLE_BYTE (8'hFF),
        .RESET_BYTE(8'h63),
        .MAG_SHIFT (11)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .axis_data(axis_data),
        .enable   (enable),
        .recenter (recenter),
        .tx       (tx_if),
        .cur_axis (cur_axis),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (tx_if.tx_send) send_cnt <= send_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_axes(input logic signed [15:0] a0, input logic signed [15:0] a1);
        axis_data = {a1, a0};
    endtask

    // One tick with tx_ready high: strobe exactly two cycles after the tick.
    task automatic slot(input string tag, input logic [7:0] exp, input logic [3:0] axis_after);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        check({tag, " busy"}, busy, 1);
        check({tag, " early"}, tx_if.tx_send, 0);
        @(negedge clk);
        check({tag, " send"}, tx_if.tx_send, 1);
        check({tag, " data"}, tx_if.tx_data, exp);
        @(negedge clk);
        check({tag, " idle"}, busy, 0);
        check({tag, " axis"}, cur_axis, axis_after);
    endtask

    initial begin
        tx_if.tx_ready = 1'b1;
        enable = 1'b1;
        #12;
        check("rst send", tx_if.tx_send, 0);
        check("rst data", tx_if.tx_data, 8'h00);
        check("rst busy", busy, 0);
        check("rst axis", cur_axis, 0);
        check("rst drop", drop_cnt, 0);
        @(negedge clk); rst = 1'b1;

        slot("t1 reset byte", 8'h63, 4'd0);

        set_axes(16'sd5000, -16'sd5000);
        slot("t2 a0", 8'h01, 4'd1);
        slot("t2 a1", 8'h02, 4'd0);
        slot("t2 a0b", 8'h01, 4'd1);
        slot("t2 a1b", 8'h02, 4'd0);

        slot("t3 5000", 8'h01, 4'd1);
        slot("t3 a1", 8'h02, 4'd0);
        set_axes(16'sd3500, -16'sd5000);
        slot("t3 3500", 8'h01, 4'd1);
        slot("t3 a1b", 8'h02, 4'd0);
        set_axes(16'sd2900, -16'sd5000);
        slot("t3 2900", 8'hFF, 4'd1);
        slot("t3 a1c", 8'h02, 4'd0);
        set_axes(-16'sd4097, -16'sd5000);
        slot("t3 -4097", 8'h00, 4'd1);
        slot("t3 a1d", 8'h02, 4'd0);

        // Ticks with enable low are neither serviced nor counted.
        @(negedge clk); enable = 1'b0; tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        check("dis busy", busy, 0);
        check("dis drop", drop_cnt, 0);
        @(negedge clk);
        check("dis send", tx_if.tx_send, 0);
        enable = 1'b1;

        // Stall: three consecutive ticks, one slot plus two drops.
        tx_if.tx_ready = 1'b0;
        snap_cnt = send_cnt;
        @(negedge clk); tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); tick = 1'b0;
        check("t4 drop2", drop_cnt, 8'd2);
        check("t4 busy", busy, 1);
        repeat (3) @(negedge clk);
        check("t4 held send", tx_if.tx_send, 0);
        check("t4 held data", tx_if.tx_data, 8'h00);
        check("t4 no strobe", send_cnt, snap_cnt);
        tx_if.tx_ready = 1'b1;
        #1;
        check("t4 release send", tx_if.tx_send, 1);
        @(negedge clk);
        check("t4 one strobe", send_cnt, snap_cnt + 1);
        check("t4 after send", tx_if.tx_send, 0);
        check("t4 axis", cur_axis, 1);

        tx_if.tx_ready = 1'b0;
        tick = 1'b1;
        repeat (300) @(negedge clk);
        tick = 1'b0;
        check("t4 sat", drop_cnt, 8'd255);
        check("t4 sat busy", busy, 1);
        tx_if.tx_ready = 1'b1;
        @(negedge clk);
        check("t4 sat data", tx_if.tx_data, 8'h02);
        check("t4 sat axis", cur_axis, 0);
        slot("t4 a0", 8'h00, 4'd1);

        // Recenter coinciding with a tick turns that slot into a reset slot.
        @(negedge clk); tick = 1'b1; recenter = 1'b1;
        @(negedge clk); tick = 1'b0; recenter = 1'b0;
        @(negedge clk);
        check("t5 send", tx_if.tx_send, 1);
        check("t5 data", tx_if.tx_data, 8'h63);
        @(negedge clk);
        check("t5 axis kept", cur_axis, 1);
        set_axes(-16'sd4097, -16'sd32768);
        slot("t5 min", 8'h02, 4'd0);
        check("t5 drop kept", drop_cnt, 8'd255);

        set_axes(16'sd10241, -16'sd32768);
`ifdef GYRO_CMD_MAG_EN
        slot("t6 mag", 8'hC1, 4'd1);
`else
        slot("t6 mag", 8'h01, 4'd1);
`endif

        // Reset while waiting in ISSUE must abort the slot without a strobe.
        tx_if.tx_ready = 1'b0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
        check("t6 pre busy", busy, 1);
        snap_cnt = send_cnt;
        #1 rst = 1'b0;
        #1;
        check("t6 rst busy", busy, 0);
        check("t6 rst send", tx_if.tx_send, 0);
        check("t6 rst data", tx_if.tx_data, 8'h00);
        check("t6 rst axis", cur_axis, 0);
        check("t6 rst drop", drop_cnt, 0);
        tx_if.tx_ready = 1'b1;
        #1;
        check("t6 rst ready", tx_if.tx_send, 0);
        @(negedge clk);
        @(negedge clk);
        check("t6 no strobe", send_cnt, snap_cnt);
        rst = 1'b1;
        slot("t6 post reset", 8'h63, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gyro_cmd_encoder.md
Name: gyro_cmd_encoder

Overview:
Generalised gyro-to-command encoder for the glove controller. Takes NUM_AXES signed rate samples, classifies each axis as negative, neutral or positive using a deadzone with hysteresis, and emits one command byte per tick over a ready/send byte handshake to the UART transmitter. Axes are serviced round-robin. A cursor-reset byte is sent after reset and on request. Sits between the gyro SPI reader and the UART.

Parameters:
NUM_AXES, 2, number of axes serviced; legal range 1..16.
DATA_W, 16, width of each signed axis sample.
DEADZONE, 4096, an axis enters the pos/neg state when |v| > DEADZONE.
HYST, 1024, an axis returns to neutral when |v| < DEADZONE-HYST; requires HYST < DEADZONE.
IDLE_BYTE, 8'hFF, byte sent for a neutral axis.
RESET_BYTE, 8'h63, cursor-reset byte.
MAG_SHIFT, 11, magnitude quantiser shift; used only with GYRO_CMD_MAG_EN.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset (0 = reset)
tick  in  1  one-cycle send-slot pulse
axis_data  in  NUM_AXES*DATA_W  packed signed samples; axis i is [i*DATA_W +: DATA_W]
enable  in  1  1 = service ticks
recenter  in  1  one-cycle request to send RESET_BYTE
tx_ready  in  1  UART can accept a byte
tx_send  out  1  one-cycle byte strobe
tx_data  out  8  command byte; stable while tx_send=1 and until the next issue
cur_axis  out  4  axis serviced in the next axis slot
busy  out  1  slot in progress (captured, not yet sent)
drop_cnt  out  8  saturating count of ticks lost while busy

Behaviour:
- Reset (rst=0, async): tx_send=0, tx_data=0, busy=0, cur_axis=0, drop_cnt=0, every axis state=NEUTRAL, recenter_pending=1. State machine is IDLE.
- The recenter pulse sets recenter_pending. It is cleared when RESET_BYTE issues.
- States: IDLE, CAPTURE, ISSUE.
- IDLE: when tick=1 and enable=1, set busy=1 and go to CAPTURE.
  - If recenter_pending, the slot is a reset slot.
  - Otherwise snapshot axis_data[cur_axis] and make it an axis slot.
- CAPTURE (1 cycle):
  - Reset slot: tx_data=RESET_BYTE.
  - Axis slot: update the hysteresis state of cur_axis using the snapshot v and |v| (computed in DATA_W+1 bits so the most negative value is handled):
    - NEUTRAL to POS when v > DEADZONE; to NEG when v < -DEADZONE.
    - POS or NEG to NEUTRAL when |v| < DEADZONE-HYST.
    - POS to NEG directly when v < -DEADZONE, and NEG to POS symmetrically.
  - Byte from the new state: NEUTRAL gives IDLE_BYTE; otherwise {3'b000, axis[3:0], dir} with dir=0 for NEG and 1 for POS. With NUM_AXES=2 the bytes are 0/1 for axis 0 and 2/3 for axis 1.
  - Go to ISSUE.
- ISSUE: on the first cycle with tx_ready=1, tx_send=1 for exactly one cycle, busy goes to 0, return to IDLE.
  - After an axis slot, cur_axis advances by 1 and wraps NUM_AXES-1 to 0.
  - A reset slot does not advance cur_axis.
- Latency: tick at cycle T with tx_ready held high gives tx_send at T+2.
- A tick while busy=1 is ignored and drop_cnt increments, saturating at 255. Ticks with enable=0 are ignored and not counted.
- A recenter in the same cycle as a tick that starts a slot takes effect that slot; the slot becomes a reset slot.
- enable going low mid-slot: the slot completes normally.
- tx_ready low indefinitely: stay in ISSUE with tx_data held and tx_send=0.
- Reset asserted mid-slot: all state returns to reset values immediately; no partial strobe.

Optional Feature:
GYRO_CMD_MAG_EN
- Defined: non-neutral bytes become {level[1:0], 1'b0, axis[3:0], dir}, where level = min(3, (|v|-DEADZONE-1) >> MAG_SHIFT), computed in CAPTURE from the snapshot. Neutral and reset bytes are unchanged.
- Not defined: level logic is absent and byte bits [7:5] are 3'b000.

Test Plan:
1. Release reset with tx_ready=1, pulse tick -> tx_send at T+2 with tx_data=8'h63; cur_axis stays 0.
2. NUM_AXES=2, axis0=+5000, axis1=-5000, four ticks after the reset byte -> bytes 8'h01, 8'h02, 8'h01, 8'h02; cur_axis sequence 0,1,0,1.
3. Hysteresis on axis0: samples +5000, +3500, +2900 on successive axis0 slots -> 8'h01, 8'h01, 8'hFF; then -4097 -> 8'h00.
4. Hold tx_ready=0, pulse tick 3 times -> one slot pending, drop_cnt=2; raise tx_ready -> a single tx_send; 300 ticks while stalled -> drop_cnt saturates at 255.
5. recenter in the same cycle as a tick with cur_axis=1 -> 8'h63 sent, cur_axis stays 1, the next slot sends the axis-1 byte; axis value -32768 -> 8'h02, no overflow.
6. GYRO_CMD_MAG_EN defined, axis0 = +10241 -> level=min(3,6144>>11)=3, byte=8'hC1; rst pulled low while in ISSUE -> tx_send never asserts and all outputs return to reset values.
